// File: rtl/method_call_sequencer.sv
// Replays a table of argument triples through a req/busy/return method port
// and checks each 1-bit return against the stored expectation.
module method_call_sequencer #(
  parameter int ARG_W   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 10000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [ARG_W-1:0]           load_c1,
  input  logic [ARG_W-1:0]           load_c2,
  input  logic [ARG_W-1:0]           load_c3,
  input  logic                       load_expect,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic                       start,
  output logic [ARG_W-1:0]           method_c1,
  output logic [ARG_W-1:0]           method_c2,
  output logic [ARG_W-1:0]           method_c3,
  output logic                       method_req,
  input  logic                       method_busy,
  input  logic                       method_return,
  output logic                       run_busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH):0]     fail_count,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    CHECK,
    DONE
  } state_t;

  state_t           state;
  logic [ARG_W-1:0] tab_c1  [DEPTH];
  logic [ARG_W-1:0] tab_c2  [DEPTH];
  logic [ARG_W-1:0] tab_c3  [DEPTH];
  logic             tab_exp [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    last_idx;
  logic [TW-1:0]    cyc_cnt;
  logic             ret_q;
  logic             mismatch;
  logic [CW-1:0]    fail_next;
  logic             cyc_expired;

  // A count of zero selects the whole table.
  function automatic logic [AW-1:0] last_index(input logic [CW-1:0] n);
    logic [CW-1:0] eff;
    eff = (n == '0) ? CW'(DEPTH) : n;
    return AW'(eff - CW'(1));
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    if (!inc || v == CW'(DEPTH)) return v;
    return v + CW'(1);
  endfunction

  // Table storage carries no reset so contents survive across runs.
  always_ff @(posedge clk) begin
    if (load_we && state == IDLE) begin
      tab_c1[load_addr]  <= load_c1;
      tab_c2[load_addr]  <= load_c2;
      tab_c3[load_addr]  <= load_c3;
      tab_exp[load_addr] <= load_expect;
    end
  end

  always_comb begin
    mismatch    = (ret_q != tab_exp[idx]);
    fail_next   = sat_inc(fail_count, mismatch);
    cyc_expired = (cyc_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      method_req <= 1'b0;
      method_c1  <= '0;
      method_c2  <= '0;
      method_c3  <= '0;
      run_busy   <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      timeout    <= 1'b0;
      idx        <= '0;
      last_idx   <= '0;
      cyc_cnt    <= '0;
      ret_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            last_idx   <= last_index(count);
            fail_count <= '0;
            timeout    <= 1'b0;
            pass       <= 1'b0;
            idx        <= '0;
            run_busy   <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          method_c1  <= tab_c1[idx];
          method_c2  <= tab_c2[idx];
          method_c3  <= tab_c3[idx];
          method_req <= 1'b1;
          cyc_cnt    <= '0;
          state      <= WAIT_ACK;
        end
        // The timeout budget spans both wait states of one call.
        WAIT_ACK: begin
          cyc_cnt <= cyc_cnt + TW'(1);
          if (cyc_expired) begin
            timeout    <= 1'b1;
            method_req <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            state      <= DONE;
          end else if (method_busy) begin
            method_req <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          cyc_cnt <= cyc_cnt + TW'(1);
          if (cyc_expired) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= DONE;
          end else if (!method_busy) begin
            ret_q <= method_return;
            state <= CHECK;
          end
        end
        // done and pass are raised on entry to DONE so they share a cycle.
        CHECK: begin
          fail_count <= fail_next;
          if (idx == last_idx) begin
            done  <= 1'b1;
            pass  <= (fail_next == '0);
            state <= DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= ISSUE;
          end
        end
        DONE: begin
          run_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_method_call_sequencer.sv
// Scoreboard bench for method_call_sequencer with a behavioural method model.
module tb_method_call_sequencer;

  localparam int ARG_W   = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 300;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  typedef logic [3*ARG_W-1:0] call_t;
  typedef struct packed {
    logic [CW-1:0] fails;
    logic          exp_pass;
    logic          tmo;
    logic          chk_lat;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [ARG_W-1:0] load_c1 = '0, load_c2 = '0, load_c3 = '0;
  logic load_expect = 1'b0;
  logic [CW-1:0] count = '0;
  logic start = 1'b0;
  logic [ARG_W-1:0] method_c1, method_c2, method_c3;
  logic method_req;
  logic method_busy = 1'b0;
  logic method_return = 1'b0;
  logic run_busy, done, pass, timeout;
  logic [CW-1:0] fail_count;

  method_call_sequencer #(.ARG_W(ARG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .load_we(load_we), .load_addr(load_addr),
    .load_c1(load_c1), .load_c2(load_c2), .load_c3(load_c3),
    .load_expect(load_expect), .count(count), .start(start),
    .method_c1(method_c1), .method_c2(method_c2), .method_c3(method_c3),
    .method_req(method_req), .method_busy(method_busy), .method_return(method_return),
    .run_busy(run_busy), .done(done), .pass(pass),
    .fail_count(fail_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: what the table should hold and what the method will return.
  logic [ARG_W-1:0] t_c1 [DEPTH];
  logic [ARG_W-1:0] t_c2 [DEPTH];
  logic [ARG_W-1:0] t_c3 [DEPTH];
  bit               t_exp [DEPTH];
  bit               plan_ret [DEPTH];

  call_t exp_calls[$];
  bit    ret_plan[$];
  res_t  sb[$];

  bit never_busy = 1'b0;
  int busy_len = 1;
  int done_seen = 0;
  int done_target = 0;
  bit last_pass = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Method model: busy rises the cycle after req is seen, holds for busy_len
  // cycles, and shows the inverted return while busy to expose early sampling.
  int    m_phase = 0;
  int    m_left = 0;
  bit    m_ret = 1'b0;
  call_t m_args = '0;
  call_t m_exp = '0;
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = 0;
        method_busy = 1'b0;
        method_return = 1'b0;
      end else begin
        case (m_phase)
          0: if (method_req) begin
            if (exp_calls.size() == 0) fail_now("unexpected_call");
            else begin
              m_exp = exp_calls.pop_front();
              check("call_args", 128'({method_c1, method_c2, method_c3}), 128'(m_exp));
            end
            m_args = {method_c1, method_c2, method_c3};
            if (never_busy) m_phase = 3;
            else begin
              m_ret = (ret_plan.size() > 0) ? ret_plan.pop_front() : 1'b0;
              m_left = busy_len;
              m_phase = 1;
              #1;
              method_busy = 1'b1;
              method_return = ~m_ret;
            end
          end
          1: if (m_left <= 1) begin
            check("args_stable", 128'({method_c1, method_c2, method_c3}), 128'(m_args));
            m_phase = 0;
            #1;
            method_busy = 1'b0;
            method_return = m_ret;
          end else m_left--;
          3: if (!method_req) m_phase = 0;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every done pulse.
  int   cyc = 0;
  int   req_rise_cyc = 0;
  int   req_len = 0;
  logic req_prev = 1'b0;
  res_t mon_it;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        req_prev = 1'b0;
        req_len = 0;
      end else begin
        if (method_req && !req_prev) req_rise_cyc = cyc;
        if (method_req) req_len++;
        else begin
          if (req_prev) check("req_min_len", 128'(req_len >= 2), 128'(1));
          req_len = 0;
        end
        req_prev = method_req;
        if (done) begin
          done_seen++;
          if (sb.size() == 0) fail_now("unexpected_done");
          else begin
            mon_it = sb.pop_front();
            check("fail_count", 128'(fail_count), 128'(mon_it.fails));
            check("pass", 128'(pass), 128'(mon_it.exp_pass));
            check("timeout", 128'(timeout), 128'(mon_it.tmo));
            check("run_busy_at_done", 128'(run_busy), 128'(1));
            check("req_low_at_done", 128'(method_req), 128'(0));
            if (mon_it.chk_lat) check("timeout_latency", 128'(cyc - req_rise_cyc), 128'(TIMEOUT));
          end
        end
      end
    end
  end

  task automatic drive_load(input int a, input logic [ARG_W-1:0] c1, input logic [ARG_W-1:0] c2,
                            input logic [ARG_W-1:0] c3, input bit e);
    load_we = 1'b1;
    load_addr = AW'(a);
    load_c1 = c1;
    load_c2 = c2;
    load_c3 = c3;
    load_expect = e;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic load_entry(input int a, input logic [ARG_W-1:0] c1, input logic [ARG_W-1:0] c2,
                            input logic [ARG_W-1:0] c3, input bit e);
    t_c1[a] = c1;
    t_c2[a] = c2;
    t_c3[a] = c3;
    t_exp[a] = e;
    drive_load(a, c1, c2, c3, e);
  endtask

  task automatic issue(input int cnt);
    int   n;
    int   f;
    res_t it;
    n = (cnt == 0) ? DEPTH : cnt;
    f = 0;
    if (never_busy) begin
      exp_calls.push_back({t_c1[0], t_c2[0], t_c3[0]});
      it = '{fails: '0, exp_pass: 1'b0, tmo: 1'b1, chk_lat: 1'b1};
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_calls.push_back({t_c1[i], t_c2[i], t_c3[i]});
        ret_plan.push_back(plan_ret[i]);
        if (plan_ret[i] != t_exp[i]) f++;
      end
      it = '{fails: CW'(f), exp_pass: (f == 0), tmo: 1'b0, chk_lat: 1'b0};
    end
    sb.push_back(it);
    last_pass = it.exp_pass;
    done_target = done_seen + 1;
    start = 1'b1;
    count = CW'(cnt);
    @(negedge clk);
    start = 1'b0;
    check("run_busy_after_start", 128'(run_busy), 128'(1));
    check("req_in_issue", 128'(method_req), 128'(0));
    @(negedge clk);
    check("req_after_issue", 128'(method_req), 128'(1));
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_seen < done_target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_seen < done_target) fail_now("done_wait_expired");
    check("calls_remaining", 128'(exp_calls.size()), 128'(0));
    repeat (2) @(negedge clk);
    check("pass_held", 128'(pass), 128'(last_pass));
    check("run_busy_idle", 128'(run_busy), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 128'(method_req), 128'(0));
    check({tag, "_args"}, 128'({method_c1, method_c2, method_c3}), 128'(0));
    check({tag, "_run_busy"}, 128'(run_busy), 128'(0));
    check({tag, "_done"}, 128'(done), 128'(0));
    check({tag, "_pass"}, 128'(pass), 128'(0));
    check({tag, "_fail_count"}, 128'(fail_count), 128'(0));
    check({tag, "_timeout"}, 128'(timeout), 128'(0));
  endtask

  task automatic set_plan_to_expect();
    for (int i = 0; i < DEPTH; i++) plan_ret[i] = t_exp[i];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single entry with a 3-cycle busy.
    load_entry(0, 32'd1, 32'd2, 32'hFFFF_FFFE, 1'b1);
    plan_ret[0] = 1'b1;
    busy_len = 3;
    issue(1);
    wait_done(200);

    // Eight entries, alternating expectations, method always returns 1.
    for (int i = 0; i < DEPTH; i++) load_entry(i, $urandom, $urandom, $urandom, (i % 2) == 0);
    for (int i = 0; i < DEPTH; i++) plan_ret[i] = 1'b1;
    busy_len = 2;
    issue(8);
    wait_done(400);

    // count=0 runs the whole table.
    issue(0);
    wait_done(400);

    // Method never answers.
    never_busy = 1'b1;
    issue(3);
    wait_done(TIMEOUT + 100);
    never_busy = 1'b0;

    // Start and load_we during a run are ignored; a rerun proves the table is intact.
    set_plan_to_expect();
    busy_len = 4;
    issue(8);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive_load(2, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, ~t_exp[2]);
    wait_done(600);
    issue(8);
    wait_done(600);

    // Short and long busy give the same verdict.
    busy_len = 1;
    issue(4);
    wait_done(400);
    busy_len = 200;
    issue(4);
    wait_done(4 * 220 + TIMEOUT);

    // Asynchronous reset while waiting for busy to fall.
    busy_len = 50;
    issue(4);
    k = 0;
    while (!(method_busy && !method_req) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_wait_done", 128'(method_busy && !method_req), 128'(1));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    sb.delete();
    exp_calls.delete();
    ret_plan.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    busy_len = 2;
    issue(4);
    wait_done(400);

    // Randomized runs: fresh loads right before start, random counts and returns.
    for (int r = 0; r < 15; r++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++)
        load_entry($urandom_range(0, DEPTH - 1), $urandom, $urandom, $urandom, 1'($urandom));
      for (int i = 0; i < DEPTH; i++) plan_ret[i] = 1'($urandom);
      busy_len = $urandom_range(1, 5);
      issue($urandom_range(0, DEPTH));
      wait_done(DEPTH * 20 + 100);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
